// File: rtl/alu_seq.sv
// Registered ALU with a persistent Z/C/N/V flag register, a shift-add multiplier
// and a start/busy/done handshake. The result register drives the shared bus under oe.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             fe,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             oe,
    output logic             busy,
    output logic             done,
    output logic             zf,
    output logic             cf,
    output logic             nf,
    output logic             vf,
    inout  wire  [WIDTH-1:0] bus
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_ADC = 4'd2, OP_SBC = 4'd3,
                           OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_NOT = 4'd7,
                           OP_SHL = 4'd8, OP_SHR = 4'd9, OP_ASR = 4'd10, OP_MUL = 4'd11,
                           OP_PASSB = 4'd12;
    localparam int MSB = WIDTH - 1;
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   res;
    logic [2*WIDTH-1:0] ma, acc, acc_nxt;
    logic [WIDTH-1:0]   mb;
    logic [CW-1:0]      cnt;
    logic               mfe;
    logic               accept, is_mul, last;

    logic [WIDTH:0]     ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_wr;

    // start is ignored while the multiplier iterates
    assign accept  = start && (state != S_MUL);
    assign is_mul  = MUL_EN && (op == OP_MUL);
    assign last    = (cnt == CW'(WIDTH - 1));
    assign acc_nxt = acc + (mb[0] ? ma : '0);

    assign busy = (state == S_MUL);
    assign done = (state == S_DONE);
    assign bus  = oe ? res : {WIDTH{1'bz}};

    // Single-cycle datapath; alu_wr=0 marks ops that must leave result and flags alone.
    always_comb begin
        ext     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_wr  = 1'b1;
        unique case (op)
            OP_ADD, OP_ADC: begin
                ext     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & cf};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_SUB, OP_SBC: begin
                // The extra top bit of the difference is the borrow out
                ext     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBC) & cf};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_XOR:   alu_res = a ^ b;
            OP_NOT:   alu_res = ~a;
            OP_SHL: begin
                alu_res = a << 1;
                alu_c   = a[MSB];
            end
            OP_SHR: begin
                alu_res = a >> 1;
                alu_c   = a[0];
            end
            OP_ASR: begin
                alu_res = {a[MSB], a[WIDTH-1:1]};
                alu_c   = a[0];
            end
            OP_PASSB: alu_res = b;
            default:  alu_wr  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (accept)              state_nxt = is_mul ? S_MUL : S_DONE;
                else if (state == S_DONE) state_nxt = S_IDLE;
            end
            S_MUL:   if (last) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
            zf  <= 1'b0;
            cf  <= 1'b0;
            nf  <= 1'b0;
            vf  <= 1'b0;
            ma  <= '0;
            mb  <= '0;
            acc <= '0;
            cnt <= '0;
            mfe <= 1'b0;
        end else if (accept && is_mul) begin
            ma  <= {{WIDTH{1'b0}}, a};
            mb  <= b;
            acc <= '0;
            cnt <= '0;
            mfe <= fe;
        end else if (accept) begin
            if (alu_wr) begin
                res <= alu_res;
                if (fe) begin
                    zf <= (alu_res == '0);
                    nf <= alu_res[MSB];
                    cf <= alu_c;
                    vf <= alu_v;
                end
            end
        end else if (state == S_MUL) begin
            acc <= acc_nxt;
            ma  <= ma << 1;
            mb  <= mb >> 1;
            cnt <= cnt + 1'b1;
            if (last) begin
                res <= acc_nxt[WIDTH-1:0];
                if (mfe) begin
                    zf <= (acc_nxt[WIDTH-1:0] == '0);
                    nf <= acc_nxt[MSB];
                    cf <= |acc_nxt[2*WIDTH-1:WIDTH];
                    vf <= |acc_nxt[2*WIDTH-1:WIDTH];
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a table of single-cycle ops issued back-to-back,
// then hand sequences for done width, flag enable, bus, multiply and reset abort.
module tb_alu_seq;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, fe = 1'b0, oe = 1'b1;
    logic [3:0] op = '0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, zf, cf, nf, vf;
    wire  [7:0] bus;
    logic       drv_en = 1'b0;
    logic [7:0] drv_val = '0;
    int         n_cmp = 0, n_err = 0;

    // Bench-side driver proves the DUT releases the bus when oe=0
    assign bus = drv_en ? drv_val : 8'hzz;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .fe(fe), .a(a), .b(b),
        .oe(oe), .busy(busy), .done(done), .zf(zf), .cf(cf), .nf(nf), .vf(vf), .bus(bus)
    );

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       fe;
        logic [7:0] res;
        logic [3:0] flg;   // {z,c,n,v}
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic f);
        start = 1'b1; op = o; a = x; b = y; fe = f;
    endtask

    initial begin
        logic seen;
        tbl[0]  = '{4'd0,  8'h7F, 8'h01, 1'b1, 8'h80, 4'b0011};
        tbl[1]  = '{4'd1,  8'h05, 8'h07, 1'b1, 8'hFE, 4'b0110};
        tbl[2]  = '{4'd3,  8'h10, 8'h01, 1'b1, 8'h0E, 4'b0000};
        tbl[3]  = '{4'd2,  8'hFF, 8'h01, 1'b1, 8'h00, 4'b1100};
        tbl[4]  = '{4'd2,  8'h01, 8'h01, 1'b1, 8'h03, 4'b0000};
        tbl[5]  = '{4'd1,  8'h80, 8'h01, 1'b1, 8'h7F, 4'b0001};
        tbl[6]  = '{4'd4,  8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000};
        tbl[7]  = '{4'd5,  8'h0F, 8'h30, 1'b1, 8'h3F, 4'b0000};
        tbl[8]  = '{4'd7,  8'h55, 8'h00, 1'b1, 8'hAA, 4'b0010};
        tbl[9]  = '{4'd12, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b1000};
        tbl[10] = '{4'd9,  8'h01, 8'h00, 1'b1, 8'h00, 4'b1100};
        tbl[11] = '{4'd10, 8'h80, 8'h00, 1'b1, 8'hC0, 4'b0010};
        tbl[12] = '{4'd8,  8'h81, 8'h00, 1'b1, 8'h02, 4'b0100};
        tbl[13] = '{4'd0,  8'h80, 8'h80, 1'b1, 8'h00, 4'b1101};
        tbl[14] = '{4'd1,  8'h00, 8'h00, 1'b1, 8'h00, 4'b1000};
        tbl[15] = '{4'd3,  8'h00, 8'hFF, 1'b1, 8'h01, 4'b0100};
        tbl[16] = '{4'd3,  8'h00, 8'h00, 1'b1, 8'hFF, 4'b0110};
        tbl[17] = '{4'd6,  8'h55, 8'hFF, 1'b0, 8'hAA, 4'b0110};

        // Reset state
        #2;
        chk("rst_busy_done", {busy, done}, 2'b00);
        chk("rst_flags", {zf, cf, nf, vf}, 4'b0000);
        chk("rst_bus", bus, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ADD overflow, done exactly one cycle
        issue(4'd0, 8'h7F, 8'h01, 1'b1);
        step();
        start = 1'b0;
        chk("add_done", done, 1'b1);
        chk("add_res", bus, 8'h80);
        chk("add_flags", {zf, cf, nf, vf}, 4'b0011);
        step();
        chk("add_done_drop", done, 1'b0);
        chk("add_res_hold", bus, 8'h80);

        // Table, start held high: one result per cycle
        for (int i = 0; i < 18; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].fe);
            step();
            chk($sformatf("tbl%0d_done", i), done, 1'b1);
            chk($sformatf("tbl%0d_res", i), bus, tbl[i].res);
            chk($sformatf("tbl%0d_flags", i), {zf, cf, nf, vf}, tbl[i].flg);
        end
        start = 1'b0;
        step();
        chk("tbl_idle_done", done, 1'b0);

        // fe=0 keeps zf clear; bus release under oe
        issue(4'd6, 8'hFF, 8'hFF, 1'b0);
        step();
        start = 1'b0;
        chk("xor_nofe_res", bus, 8'h00);
        chk("xor_nofe_zf", zf, 1'b0);
        oe = 1'b0; drv_en = 1'b1; drv_val = 8'h5A;
        #1;
        chk("bus_released", bus, 8'h5A);
        drv_en = 1'b0; oe = 1'b1;
        #1;
        chk("bus_driven", bus, 8'h00);
        step();
        issue(4'd0, 8'h01, 8'h01, 1'b1);
        step();
        chk("add2_res", bus, 8'h02);
        for (int o = 13; o < 16; o++) begin
            issue(4'(o), 8'hFF, 8'hFF, 1'b1);
            step();
            chk($sformatf("rsv%0d_done", o), done, 1'b1);
            chk($sformatf("rsv%0d_res", o), bus, 8'h02);
            chk($sformatf("rsv%0d_flags", o), {zf, cf, nf, vf}, 4'b0000);
        end
        start = 1'b0;
        step();

        // MUL 0x10*0x20: busy 8 cycles, mid start ignored
        issue(4'd11, 8'h10, 8'h20, 1'b1);
        step();
        chk("mul_k_busy", {busy, done}, 2'b10);
        for (int i = 1; i < 8; i++) begin
            if (i == 3) issue(4'd0, 8'h01, 8'h01, 1'b1);
            else        start = 1'b0;
            step();
            chk($sformatf("mul_k%0d_busy", i), {busy, done}, 2'b10);
            chk($sformatf("mul_k%0d_hold", i), bus, 8'h02);
        end
        start = 1'b0;
        step();
        chk("mul_done", {busy, done}, 2'b01);
        chk("mul_res", bus, 8'h00);
        chk("mul_flags", {zf, cf, nf, vf}, 4'b1101);

        // Restart MUL from DONE: 0x0D*0x0B = 0x8F
        issue(4'd11, 8'h0D, 8'h0B, 1'b1);
        step();
        start = 1'b0;
        chk("mul2_busy", {busy, done}, 2'b10);
        repeat (7) step();
        chk("mul2_still_busy", {busy, done}, 2'b10);
        step();
        chk("mul2_done", {busy, done}, 2'b01);
        chk("mul2_res", bus, 8'h8F);
        chk("mul2_flags", {zf, cf, nf, vf}, 4'b0010);
        step();

        // Reset aborts a multiply, asynchronously
        issue(4'd11, 8'hFF, 8'hFF, 1'b1);
        step();
        start = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy_done", {busy, done}, 2'b00);
        chk("abort_flags", {zf, cf, nf, vf}, 4'b0000);
        chk("abort_res", bus, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            step();
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done", seen, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
